// File: rtl/branch_ctrl.sv
// branch_ctrl: fetch PC owner; decodes B/BR/HLT in ID, resolves branches via cond_true, drives flush/stall_out/halted
module branch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        id_valid,
  input  logic [15:0] id_instr,
  input  logic [15:0] id_pc2,
  input  logic [15:0] br_reg_val,
  input  logic        ex_flag_wr,
  input  logic        cond_true,
  output logic [2:0]  cc_req,
  output logic [15:0] pc,
  output logic        flush,
  output logic        stall_out,
  output logic        halted
);
  typedef enum logic [1:0] {RUN, CC_WAIT, HALT} state_t;
  state_t state;
  logic [15:0] tgt, tgt_q, pc_inc;
  logic [3:0] op;
  logic is_br, is_hlt, hazard, active;
  assign op = id_instr[15:12];
  assign cc_req = id_instr[11:9];
  assign is_br = id_valid && (op == 4'b1100 || op == 4'b1101);
  assign is_hlt = id_valid && op == 4'b1111;
  assign tgt = op[0] ? br_reg_val : id_pc2 + {{6{id_instr[8]}}, id_instr[8:0], 1'b0};
  assign pc_inc = pc + 16'd2;
  assign active = !rst && !stall_in;
  assign hazard = is_br && cc_req != 3'b111 && ex_flag_wr;
  assign stall_out = active && state == RUN && hazard;
  assign flush = active && ((state == RUN && (is_hlt || (is_br && !hazard && cond_true))) ||
                            (state == CC_WAIT && cond_true));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      pc <= RESET_PC;
      halted <= 1'b0;
      tgt_q <= '0;
    end else if (!stall_in) begin
      if (state == RUN) begin
        if (is_hlt) begin
          state <= HALT;
          halted <= 1'b1;
        end else if (hazard) begin
          state <= CC_WAIT;
          tgt_q <= tgt;
        end else begin
          pc <= (is_br && cond_true) ? tgt : pc_inc;
        end
      end else if (state == CC_WAIT) begin
        pc <= cond_true ? tgt_q : pc_inc;
        state <= RUN;
      end
    end
  end
endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed scoreboard bench for branch_ctrl
module tb_branch_ctrl;
  logic clk = 1'b0, rst = 1'b1, stall_in = 1'b0, id_valid = 1'b0, ex_flag_wr = 1'b0, cond_true = 1'b0;
  logic [15:0] id_instr = '0, id_pc2 = '0, br_reg_val = '0;
  logic [2:0] cc_req;
  logic [15:0] pc;
  logic flush, stall_out, halted;
  int tests = 0, fails = 0;
  typedef struct {string tag; logic [15:0] val;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  branch_ctrl dut (.clk(clk), .rst(rst), .stall_in(stall_in), .id_valid(id_valid), .id_instr(id_instr),
                   .id_pc2(id_pc2), .br_reg_val(br_reg_val), .ex_flag_wr(ex_flag_wr), .cond_true(cond_true),
                   .cc_req(cc_req), .pc(pc), .flush(flush), .stall_out(stall_out), .halted(halted));
  task automatic push(input string tag, input logic [15:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty observed=%h", obs);
      return;
    end
    e = sb.pop_front();
    tests++;
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask
  task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] p2,
                       input logic [15:0] brv, input logic exw, input logic ct);
    id_valid = v; id_instr = ins; id_pc2 = p2; br_reg_val = brv; ex_flag_wr = exw; cond_true = ct;
  endtask
  task automatic comb(input string tag, input logic f, input logic s);
    #1;
    push({tag, "_flush"}, {15'd0, f}); pop({15'd0, flush});
    push({tag, "_stall"}, {15'd0, s}); pop({15'd0, stall_out});
  endtask
  task automatic tick(input string tag, input logic [15:0] p, input logic h);
    push({tag, "_pc"}, p);
    push({tag, "_halted"}, {15'd0, h});
    @(posedge clk); #1;
    pop(pc);
    pop({15'd0, halted});
  endtask
  initial begin
    drive(1'b1, 16'hC204, 16'h0010, 16'h0, 1'b1, 1'b1);
    @(posedge clk); #1;
    comb("in_reset", 1'b0, 1'b0);
    @(posedge clk); #1;
    push("reset_pc", 16'h0000); pop(pc);
    push("reset_halted", 16'h0); pop({15'd0, halted});
    rst = 1'b0;
    drive(1'b0, 16'hC204, 16'h0, 16'h0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      comb("seq", 1'b0, 1'b0);
      tick("seq", 16'(2 * i), 1'b0);
    end
    drive(1'b1, 16'hC204, 16'h0010, 16'h0, 1'b0, 1'b1);
    #1; push("cc_req_eq", 16'd1); pop({13'd0, cc_req});
    comb("b_eq_taken", 1'b1, 1'b0);
    tick("b_eq_taken", 16'h0018, 1'b0);
    drive(1'b1, 16'hC204, 16'h0010, 16'h0, 1'b0, 1'b0);
    comb("b_eq_nt", 1'b0, 1'b0);
    tick("b_eq_nt", 16'h001A, 1'b0);
    drive(1'b1, 16'hC1FF, 16'h0000, 16'h0, 1'b1, 1'b0);
    comb("b_ne_hazard", 1'b0, 1'b1);
    tick("b_ne_hazard", 16'h001A, 1'b0);
    drive(1'b1, 16'hC1FF, 16'h0000, 16'h0, 1'b1, 1'b1);
    comb("b_ne_resolve", 1'b1, 1'b0);
    tick("b_ne_resolve", 16'hFFFE, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    comb("wrap", 1'b0, 1'b0);
    tick("wrap", 16'h0000, 1'b0);
    drive(1'b1, 16'hDE00, 16'h0, 16'h1234, 1'b1, 1'b1);
    comb("br_uncond", 1'b1, 1'b0);
    tick("br_uncond", 16'h1234, 1'b0);
    drive(1'b0, 16'hDE00, 16'h0, 16'h5678, 1'b1, 1'b1);
    comb("invalid_br", 1'b0, 1'b0);
    tick("invalid_br", 16'h1236, 1'b0);
    drive(1'b1, 16'hC204, 16'h0040, 16'h0, 1'b1, 1'b0);
    comb("hz_enter", 1'b0, 1'b1);
    tick("hz_enter", 16'h1236, 1'b0);
    stall_in = 1'b1;
    drive(1'b1, 16'hC204, 16'h0040, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      comb("stall_in", 1'b0, 1'b0);
      tick("stall_in", 16'h1236, 1'b0);
    end
    stall_in = 1'b0;
    comb("stall_release", 1'b1, 1'b0);
    tick("stall_release", 16'h0048, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    comb("post_release", 1'b0, 1'b0);
    tick("post_release", 16'h004A, 1'b0);
    drive(1'b1, 16'hC204, 16'h0080, 16'h0, 1'b1, 1'b1);
    comb("hz_rst_enter", 1'b0, 1'b1);
    tick("hz_rst_enter", 16'h004A, 1'b0);
    rst = 1'b1;
    comb("hz_rst_active", 1'b0, 1'b0);
    tick("hz_rst", 16'h0000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    comb("after_rst", 1'b0, 1'b0);
    tick("after_rst", 16'h0002, 1'b0);
    drive(1'b1, 16'hF000, 16'h0, 16'h0, 1'b1, 1'b1);
    comb("hlt", 1'b1, 1'b0);
    tick("hlt", 16'h0002, 1'b1);
    drive(1'b1, 16'hC204, 16'h0100, 16'h0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      id_instr = i[0] ? 16'hDE00 : 16'hC204;
      comb("halted", 1'b0, 1'b0);
      tick("halted", 16'h0002, 1'b1);
    end
    rst = 1'b1;
    tick("halt_rst", 16'h0000, 1'b0);
    rst = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    tick("halt_rst_run", 16'h0002, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
